// File: rtl/iterative_alu.sv
// iterative_alu: single-cycle logic/arith ops, SLL/SRL shifted one bit per clock.
// Define ALU_OVERFLOW_EN to add the registered signed Overflow output.
module iterative_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         ALUOperation,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   ALUResult,
  output logic               Zero,
  output logic               error
`ifdef ALU_OVERFLOW_EN
  ,
  output logic               Overflow
`endif
);

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_NOR = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_LW  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   work, work_n;
  logic [SHAMT_W-1:0] cnt, cnt_n;
  logic               left, left_n;
  logic [WIDTH-1:0]   res_n;
  logic               zero_n, done_n, err_n;
  logic [WIDTH-1:0]   alu_res, sum, diff;
  logic               alu_ok, is_shift;
`ifdef ALU_OVERFLOW_EN
  logic               alu_ovf, ovf_n;
`endif

  assign sum      = A + B;
  assign diff     = A - B;
  assign is_shift = (ALUOperation == OP_SLL) ||
                    (ALUOperation == OP_SRL);
  assign busy     = (state == SHIFT);

  always_comb begin
    alu_res = '0;
    alu_ok  = 1'b1;
    unique case (ALUOperation)
      OP_AND:        alu_res = A & B;
      OP_OR:         alu_res = A | B;
      OP_NOR:        alu_res = ~(A | B);
      OP_ADD:        alu_res = sum;
      OP_SUB:        alu_res = diff;
      // shifts only complete here when shamt is zero
      OP_SLL, OP_SRL: alu_res = B;
      OP_LW, OP_SW:  alu_res = sum;
      default:       alu_ok  = 1'b0;
    endcase
  end

`ifdef ALU_OVERFLOW_EN
  always_comb begin
    alu_ovf = 1'b0;
    if (ALUOperation == OP_ADD)
      alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) &&
                (sum[WIDTH-1] != A[WIDTH-1]);
    else if (ALUOperation == OP_SUB)
      alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) &&
                (diff[WIDTH-1] != A[WIDTH-1]);
  end
`endif

  always_comb begin
    state_n = state;
    work_n  = work;
    cnt_n   = cnt;
    left_n  = left;
    res_n   = ALUResult;
    zero_n  = Zero;
    done_n  = 1'b0;
    err_n   = 1'b0;
`ifdef ALU_OVERFLOW_EN
    ovf_n   = Overflow;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          if (is_shift && (shamt != '0)) begin
            work_n  = B;
            cnt_n   = shamt;
            left_n  = (ALUOperation == OP_SLL);
            state_n = SHIFT;
          end else begin
            res_n  = alu_res;
            zero_n = (alu_res == '0);
            done_n = 1'b1;
            err_n  = ~alu_ok;
`ifdef ALU_OVERFLOW_EN
            ovf_n  = alu_ovf;
`endif
          end
        end
      end
      SHIFT: begin
        work_n = left ? {work[WIDTH-2:0], 1'b0}
                      : {1'b0, work[WIDTH-1:1]};
        cnt_n  = cnt - SHAMT_W'(1);
        if (cnt == SHAMT_W'(1)) begin
          res_n   = work_n;
          zero_n  = (work_n == '0);
          done_n  = 1'b1;
          state_n = IDLE;
`ifdef ALU_OVERFLOW_EN
          ovf_n   = 1'b0;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      work      <= '0;
      cnt       <= '0;
      left      <= 1'b0;
      ALUResult <= '0;
      Zero      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
`ifdef ALU_OVERFLOW_EN
      Overflow  <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      work      <= work_n;
      cnt       <= cnt_n;
      left      <= left_n;
      ALUResult <= res_n;
      Zero      <= zero_n;
      done      <= done_n;
      error     <= err_n;
`ifdef ALU_OVERFLOW_EN
      Overflow  <= ovf_n;
`endif
    end
  end

endmodule

// File: tb/tb_iterative_alu.sv
// Bench for iterative_alu: vector table, handshake/reset sequences,
// and random ops checked against an arithmetic reference model.
module tb_iterative_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  ALUOperation;
  logic [31:0] A, B;
  logic [4:0]  shamt;
  logic        busy, done, Zero, error;
  logic [31:0] ALUResult;
`ifdef ALU_OVERFLOW_EN
  logic        Overflow;
`endif

  int total = 0;
  int bad   = 0;

  iterative_alu #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .ALUOperation (ALUOperation),
    .A            (A),
    .B            (B),
    .shamt        (shamt),
    .busy         (busy),
    .done         (done),
    .ALUResult    (ALUResult),
    .Zero         (Zero),
    .error        (error)
`ifdef ALU_OVERFLOW_EN
    ,
    .Overflow     (Overflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        zero;
    logic        err;
    logic        ovf;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic get_ovf();
`ifdef ALU_OVERFLOW_EN
    return Overflow;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model straight from the opcode table
  task automatic model(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh,
                       output logic [31:0] r, output logic e,
                       output logic o, output int lat);
    longint s;
    r = 0; e = 0; o = 0; lat = 1;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: r = ~(a | b);
      4'd3: begin
        r = a + b;
        s = longint'($signed(a)) + longint'($signed(b));
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd4: begin
        r = a - b;
        s = longint'($signed(a)) - longint'($signed(b));
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd5: begin r = b << sh; lat = (sh == 0) ? 1 : int'(sh) + 1; end
      4'd6: begin r = b >> sh; lat = (sh == 0) ? 1 : int'(sh) + 1; end
      4'd7, 4'd8: r = a + b;
      default: e = 1;
    endcase
  endtask

  // Called #1 after a posedge with busy low. Optionally scrambles
  // inputs after the start edge to show they are latched.
  task automatic issue(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh,
                       input bit scramble, output int lat);
    ALUOperation = op; A = a; B = b; shamt = sh; start = 1;
    @(posedge clk); #1;
    start = 0;
    lat = 1;
    if (scramble) begin
      ALUOperation = 4'($urandom);
      A = $urandom; B = $urandom; shamt = 5'($urandom);
    end
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_op(input string name, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, input logic [31:0] er,
                          input logic ez, input logic ee,
                          input logic eo, input int el, input bit scr);
    int lat;
    issue(op, a, b, sh, scr, lat);
    chk({name, ".done"}, done, 1);
    chk({name, ".lat"}, lat, el);
    chk({name, ".res"}, ALUResult, er);
    chk({name, ".zero"}, Zero, ez);
    chk({name, ".err"}, error, ee);
    chk({name, ".busy"}, busy, 0);
`ifdef ALU_OVERFLOW_EN
    chk({name, ".ovf"}, get_ovf(), eo);
`else
    if (eo === 1'bx) chk({name, ".ovf"}, get_ovf(), 0);
`endif
    @(posedge clk); #1;
    chk({name, ".donepulse"}, {done, error}, 0);
    chk({name, ".hold"}, ALUResult, er);
  endtask

  vec_t vt[$];

  initial begin
    int lat, dones;
    logic [31:0] r;
    logic e, o;

    reset = 0; start = 0; ALUOperation = 0;
    A = 0; B = 0; shamt = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.err", error, 0);
    chk("rst.res", ALUResult, 0);
    chk("rst.zero", Zero, 0);
    reset = 1;
    @(posedge clk); #1;

    vt = '{
      '{4'd0, 32'h0000F0F0, 32'h00FF00FF, 5'd0, 32'h000000F0, 0, 0, 0, 1},
      '{4'd1, 32'h0000F0F0, 32'h00FF00FF, 5'd0, 32'h00FFF0FF, 0, 0, 0, 1},
      '{4'd2, 32'h0000F0F0, 32'h00FF00FF, 5'd0, 32'hFF000F00, 0, 0, 0, 1},
      '{4'd3, 32'h0000F0F0, 32'h00FF00FF, 5'd0, 32'h00FFF1EF, 0, 0, 0, 1},
      '{4'd4, 32'h00001234, 32'h00001234, 5'd0, 32'h00000000, 1, 0, 0, 1},
      '{4'd5, 32'h0, 32'h00000001, 5'd31, 32'h80000000, 0, 0, 0, 32},
      '{4'd6, 32'h0, 32'h80000000, 5'd4, 32'h08000000, 0, 0, 0, 5},
      '{4'd5, 32'h0, 32'h0000ABCD, 5'd0, 32'h0000ABCD, 0, 0, 0, 1},
      '{4'd6, 32'h0, 32'h0000ABCD, 5'd0, 32'h0000ABCD, 0, 0, 0, 1},
      '{4'd9, 32'h1, 32'h2, 5'd0, 32'h00000000, 1, 1, 0, 1},
      '{4'd15, 32'h1, 32'h2, 5'd3, 32'h00000000, 1, 1, 0, 1},
      '{4'd7, 32'h10010000, 32'h00000008, 5'd0, 32'h10010008, 0, 0, 0, 1},
      '{4'd8, 32'h10010000, 32'h00000008, 5'd0, 32'h10010008, 0, 0, 0, 1},
      '{4'd3, 32'h7FFFFFFF, 32'h00000001, 5'd0, 32'h80000000, 0, 0, 1, 1},
      '{4'd4, 32'h80000000, 32'h00000001, 5'd0, 32'h7FFFFFFF, 0, 0, 1, 1},
      '{4'd7, 32'h7FFFFFFF, 32'h00000001, 5'd0, 32'h80000000, 0, 0, 0, 1},
      '{4'd5, 32'h0, 32'hFFFFFFFF, 5'd1, 32'hFFFFFFFE, 0, 0, 0, 2}
    };
    foreach (vt[i])
      check_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b,
               vt[i].sh, vt[i].res, vt[i].zero, vt[i].err,
               vt[i].ovf, vt[i].lat, 0);

    // Reset mid-shift aborts without a completion
    ALUOperation = 4'd5; B = 32'h1; shamt = 5'd20; start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("abort.busy0", busy, 1);
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    #1;
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    chk("abort.res", ALUResult, 0);
    chk("abort.zero", Zero, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    dones = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("abort.nodone", dones, 0);
    chk("abort.res2", ALUResult, 0);

    // Start while busy is dropped; start with done high is taken
    ALUOperation = 4'd5; B = 32'h3; shamt = 5'd8; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (2) @(posedge clk);
    #1;
    ALUOperation = 4'd3; A = 32'd1; B = 32'd1; start = 1;
    @(posedge clk); #1;
    start = 0;
    lat = 0;
    while (!done && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("hs.done", done, 1);
    chk("hs.lat", lat, 5);
    chk("hs.res", ALUResult, 32'h300);
    ALUOperation = 4'd3; A = 32'd5; B = 32'd7; start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("hs.b2b.done", done, 1);
    chk("hs.b2b.res", ALUResult, 32'd12);
    @(posedge clk); #1;
    chk("hs.b2b.clr", done, 0);

    // Random ops vs. model, inputs scrambled during shifts
    for (int n = 0; n < 150; n++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      logic [4:0]  sh;
      int          el;
      op = 4'($urandom_range(0, 10));
      a  = $urandom;
      b  = (n % 4 == 0) ? a : $urandom;
      sh = 5'($urandom);
      if (n % 7 == 0) b = 32'h80000001;
      model(op, a, b, sh, r, e, o, el);
      check_op($sformatf("rnd%0d", n), op, a, b, sh, r,
               (r == 0), e, o, el, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iterative_alu.md
Name: iterative_alu

Overview:
- Sequential ALU directly downstream of the ALU control decoder; consumes its 4-bit ALUOperation code plus register/immediate operands and produces ALUResult and Zero.
- Logic and arithmetic ops complete in one clock.
- SLL/SRL run as an iterative 1-bit-per-cycle shifter, behind a start/busy/done handshake.
- Replaces the purely combinational ALU in the multi-cycle datapath.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SHAMT_W, 5, width of the shift-amount input.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only while busy=0.
- ALUOperation  input  4  operation code from the ALU control decoder.
- A  input  WIDTH  operand A (rs).
- B  input  WIDTH  operand B (rt or sign-extended immediate); the shifted operand for SLL/SRL.
- shamt  input  SHAMT_W  shift amount (instruction bits 10:6).
- busy  output  1  high while a shift is iterating.
- done  output  1  one-cycle pulse; result valid.
- ALUResult  output  WIDTH  registered result, held until the next completion.
- Zero  output  1  registered, equals (ALUResult==0).
- error  output  1  one-cycle pulse with done for an unsupported code.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy, done, error, Zero=0; ALUResult=0; shift counter=0. Reset mid-shift aborts the shift; no done is produced.
- Operation codes:
  - 0000 AND: A&B.
  - 0001 OR: A|B.
  - 0010 NOR: ~(A|B).
  - 0011 ADD: A+B.
  - 0100 SUB: A-B (BEQ/BNE compare).
  - 0101 SLL: B<<shamt.
  - 0110 SRL: B>>shamt, logical.
  - 0111 LW: A+B, address.
  - 1000 SW: A+B, address.
  - 1001-1111: invalid.
- Arithmetic: modulo 2^WIDTH, carry discarded. Shifts fill with zeros.
- States: IDLE, SHIFT.
- IDLE with start=1, at rising edge N:
  - Non-shift code, or shift with shamt=0: ALUResult, Zero and done=1 are registered at edge N. busy stays 0. State stays IDLE. Latency = 1 edge.
  - Invalid code: ALUResult=0, Zero=1, done=1, error=1 at edge N.
  - Shift with shamt=k>0: load work=B and cnt=k; busy=1; go to SHIFT.
- SHIFT, each edge:
  - work shifted 1 bit in the selected direction; cnt decrements.
  - On the edge where cnt==1: ALUResult=final work, Zero updated, done=1, busy=0, back to IDLE.
  - Done is registered at edge N+k; total latency k+1 edges.
  - Direction and count are latched at edge N. Changes to A/B/shamt/ALUOperation during SHIFT have no effect.
- start while busy=1: ignored, not queued. Start on the cycle done is high with busy=0 is accepted (back-to-back ops).
- done and error: high for exactly one cycle, cleared on the next edge unless another completion occurs there.
- shamt >= WIDTH (only when SHAMT_W allows it): iterates the full k cycles; result 0.
- ALUResult/Zero: change only at completion edges.

Optional Feature:
- Macro ALU_OVERFLOW_EN.
- Defined: adds output port Overflow (1 bit), registered and reset to 0, updated only at completion edges.
  - ADD (0011): Overflow = signed overflow, (A[msb]==B[msb]) && (res[msb]!=A[msb]).
  - SUB (0100): Overflow = (A[msb]!=B[msb]) && (res[msb]!=A[msb]).
  - All other codes, including LW/SW: Overflow = 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset mid-shift: start SLL with B=1, shamt=20; assert reset low 3 cycles later -> busy=0, done never pulses, ALUResult=0, Zero=0 after release.
- Single-cycle ops: A=0x0000F0F0, B=0x00FF00FF.
  - AND -> 0x000000F0, done pulse 1 cycle after start edge, busy=0.
  - NOR -> 0xFF000F00.
  - SUB with A=B=0x1234 -> ALUResult=0, Zero=1.
- Iterative shifts:
  - SLL B=0x00000001, shamt=31 -> busy high 31 cycles, done at edge N+31, ALUResult=0x80000000.
  - SRL B=0x80000000, shamt=4 -> 0x08000000 after 5 edges.
  - shamt=0 -> result = B in 1 edge.
- Handshake: during SLL with shamt=8, pulse start with ADD -> ignored. Issue ADD A=5, B=7 on the cycle done rises -> accepted, next done gives 12.
- Invalid/address codes:
  - 1001 -> ALUResult=0, Zero=1, done and error pulse together.
  - 0111 and 1000 with A=0x10010000, B=0x00000008 -> 0x10010008, error=0.
- ALU_OVERFLOW_EN: ADD 0x7FFFFFFF+1 -> Overflow=1; SUB 0x80000000-1 -> Overflow=1; LW on the same operands -> Overflow=0.
